// File: rtl/lighthouse_emulator_pkg.sv
// lighthouse_emulator_pkg: register map, CTRL bit positions and FSM state type
package lighthouse_emulator_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_PERIOD  = 3'd1;
    localparam logic [2:0] REG_DELAY0  = 3'd2;
    localparam logic [2:0] REG_DELAY1  = 3'd3;
    localparam logic [2:0] REG_SPACING = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_DATA = 1;
    localparam int CTRL_SKIP = 2;
    localparam logic [31:0] FILLER = 32'hDEAD_BEEF;
endpackage

// File: rtl/lighthouse_emulator_if.sv
// lighthouse_emulator_if: Avalon-MM slave bus of the lighthouse emulator
interface lighthouse_emulator_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    modport master (output address, write, writedata, read, input readdata, waitrequest);
    modport slave (input address, write, writedata, read, output readdata, waitrequest);
endinterface

// File: rtl/lighthouse_sweep_slot.sv
// lighthouse_sweep_slot: per-sensor sweep window compare merged with sync, registered
module lighthouse_sweep_slot #(
    parameter int SWEEP_WIDTH = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        active,
    input  logic        sync,
    input  logic [31:0] t,
    input  logic [31:0] start,
    input  logic [31:0] period,
    output logic        pulse
);
    logic hit;
    // 33-bit end compare so start+width never wraps
    assign hit = t >= start && {1'b0, t} < {1'b0, start} + 33'(SWEEP_WIDTH) && t < period;
    always_ff @(posedge clock or posedge reset)
        if (reset) pulse <= 1'b0;
        else pulse <= active && (sync || hit);
endmodule

// File: rtl/lighthouse_emulator.sv
// lighthouse_emulator: Avalon-MM lighthouse waveform generator (sync + per-sensor sweeps)
module lighthouse_emulator
    import lighthouse_emulator_pkg::*;
#(
    parameter int NUM_SENSORS    = 16,
    parameter int SYNC_BASE      = 3125,
    parameter int SYNC_STEP      = 521,
    parameter int SWEEP_WIDTH    = 50,
    parameter int DEFAULT_PERIOD = 416666
) (
    input  logic                   clock,
    input  logic                   reset,
    lighthouse_emulator_if.slave   bus,
    output logic [NUM_SENSORS-1:0] sensor_signal_o
);
    localparam logic [31:0] MIN_PERIOD = 32'(SYNC_BASE + 7 * SYNC_STEP + 1);

    state_t      state;
    logic [2:0]  ctrl, ctrl_n, ld_ctrl;
    logic [31:0] period, delay0, delay1, spacing;
    logic [31:0] period_n, delay0_n, delay1_n, spacing_n;
    logic [31:0] ld_period, ld_delay0, ld_delay1, ld_spacing;
    logic [31:0] sh_period, sh_delay0, sh_delay1, sh_spacing;
    logic [31:0] t, sync_len, sweep_base;
    logic        sh_data, sh_skip, axis, idle, wrap, load, sync, unused_read;
    logic [29:0] frame_cnt;

    always_comb begin
        ctrl_n     = (bus.write && bus.address == REG_CTRL) ? bus.writedata[2:0] : ctrl;
        period_n   = (bus.write && bus.address == REG_PERIOD) ? bus.writedata : period;
        delay0_n   = (bus.write && bus.address == REG_DELAY0) ? bus.writedata : delay0;
        delay1_n   = (bus.write && bus.address == REG_DELAY1) ? bus.writedata : delay1;
        spacing_n  = (bus.write && bus.address == REG_SPACING) ? bus.writedata : spacing;
        idle       = state == IDLE;
        wrap       = !idle && t == sh_period - 32'd1;
        // entry sees this cycle's write; wrap decisions use the pre-write registers
        load       = idle ? ctrl_n[CTRL_EN] : wrap;
        ld_ctrl    = idle ? ctrl_n : ctrl;
        ld_period  = idle ? period_n : period;
        ld_delay0  = idle ? delay0_n : delay0;
        ld_delay1  = idle ? delay1_n : delay1;
        ld_spacing = idle ? spacing_n : spacing;
        sync_len   = 32'(SYNC_BASE) + 32'({sh_skip, sh_data, axis}) * 32'(SYNC_STEP);
        sync       = t < sync_len;
        sweep_base = axis ? sh_delay1 : sh_delay0;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            ctrl    <= '0;
            period  <= 32'(DEFAULT_PERIOD);
            delay0  <= 32'd100000;
            delay1  <= 32'd100000;
            spacing <= 32'd1000;
        end else begin
            ctrl    <= ctrl_n;
            period  <= period_n;
            delay0  <= delay0_n;
            delay1  <= delay1_n;
            spacing <= spacing_n;
        end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state      <= IDLE;
            t          <= '0;
            axis       <= 1'b0;
            frame_cnt  <= '0;
            sh_period  <= '0;
            sh_delay0  <= '0;
            sh_delay1  <= '0;
            sh_spacing <= '0;
            sh_data    <= 1'b0;
            sh_skip    <= 1'b0;
        end else if (load) begin
            state      <= (idle || ctrl[CTRL_EN]) ? RUN : IDLE;
            t          <= '0;
            axis       <= !idle && !axis;
            frame_cnt  <= idle ? frame_cnt : frame_cnt + 30'd1;
            sh_period  <= ld_period < MIN_PERIOD ? MIN_PERIOD : ld_period;
            sh_delay0  <= ld_delay0;
            sh_delay1  <= ld_delay1;
            sh_spacing <= ld_spacing;
            sh_data    <= ld_ctrl[CTRL_DATA];
            sh_skip    <= ld_ctrl[CTRL_SKIP];
        end else if (!idle) begin
            t <= t + 32'd1;
        end

    always_comb
        case (bus.address)
            REG_CTRL:    bus.readdata = {29'd0, ctrl};
            REG_PERIOD:  bus.readdata = period;
            REG_DELAY0:  bus.readdata = delay0;
            REG_DELAY1:  bus.readdata = delay1;
            REG_SPACING: bus.readdata = spacing;
            REG_STATUS:  bus.readdata = {!idle, axis, frame_cnt};
            default:     bus.readdata = FILLER;
        endcase

    assign bus.waitrequest = 1'b0;
    assign unused_read = bus.read;

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_slot
        lighthouse_sweep_slot #(.SWEEP_WIDTH(SWEEP_WIDTH)) u_slot (
            .clock  (clock),
            .reset  (reset),
            .active (!idle),
            .sync   (sync),
            .t      (t),
            .start  (sweep_base + 32'(i) * sh_spacing),
            .period (sh_period),
            .pulse  (sensor_signal_o[i])
        );
    end
endmodule

// File: tb/tb_lighthouse_emulator.sv
// tb_lighthouse_emulator: directed stimulus, frame-level envelope model and literal timing checks
module tb_lighthouse_emulator;
    localparam int SB = 20, SS = 4, SW = 3, MINP = 49;

    typedef struct packed {
        logic [31:0] p, d0, d1, sp;
        logic        data, skip;
    } frame_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] sensor_signal_o;
    int checks = 0, errors = 0, pos = 0;

    lighthouse_emulator_if bus ();

    lighthouse_emulator #(
        .NUM_SENSORS(4), .SYNC_BASE(SB), .SYNC_STEP(SS), .SWEEP_WIDTH(SW), .DEFAULT_PERIOD(200)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .sensor_signal_o(sensor_signal_o)
    );

    always #5 clock = ~clock;

    // model: live registers, frame parameters captured at frame start, envelope from window rules
    logic [2:0]  m_ctrl, n_ctrl;
    logic [31:0] m_per, m_d0, m_d1, m_sp, m_t, n_per, n_d0, n_d1, n_sp;
    logic        m_run, m_ax;
    frame_t      m_f;
    logic [3:0]  exp_out;

    assign n_ctrl = (bus.write && bus.address == 3'd0) ? bus.writedata[2:0] : m_ctrl;
    assign n_per  = (bus.write && bus.address == 3'd1) ? bus.writedata : m_per;
    assign n_d0   = (bus.write && bus.address == 3'd2) ? bus.writedata : m_d0;
    assign n_d1   = (bus.write && bus.address == 3'd3) ? bus.writedata : m_d1;
    assign n_sp   = (bus.write && bus.address == 3'd4) ? bus.writedata : m_sp;

    function automatic frame_t cap(logic [31:0] p, d0, d1, sp, logic [2:0] c);
        frame_t f;
        f.p = (p < MINP) ? 32'(MINP) : p;
        f.d0 = d0;
        f.d1 = d1;
        f.sp = sp;
        f.data = c[1];
        f.skip = c[2];
        return f;
    endfunction

    function automatic logic [3:0] env(logic [31:0] t, logic ax, frame_t f);
        logic [3:0] v;
        logic [31:0] s;
        int code;
        code = 4 * int'(f.skip) + 2 * int'(f.data) + int'(ax);
        for (int i = 0; i < 4; i++) begin
            s = (ax ? f.d1 : f.d0) + 32'(i) * f.sp;
            v[i] = (t < 32'(SB + code * SS)) || (t >= s && t - s < SW);
        end
        return v;
    endfunction

    always @(posedge clock or posedge reset)
        if (reset) begin
            m_ctrl <= 3'd0; m_per <= 32'd200; m_d0 <= 32'd100000; m_d1 <= 32'd100000; m_sp <= 32'd1000;
            m_run <= 1'b0; m_t <= 32'd0; m_ax <= 1'b0; m_f <= '0; exp_out <= 4'd0;
        end else begin
            exp_out <= m_run ? env(m_t, m_ax, m_f) : 4'd0;
            m_ctrl <= n_ctrl; m_per <= n_per; m_d0 <= n_d0; m_d1 <= n_d1; m_sp <= n_sp;
            if (!m_run) begin
                if (n_ctrl[0]) begin
                    m_run <= 1'b1; m_t <= 32'd0; m_ax <= 1'b0;
                    m_f <= cap(n_per, n_d0, n_d1, n_sp, n_ctrl);
                end
            end else if (m_t == m_f.p - 32'd1) begin
                m_t <= 32'd0; m_ax <= !m_ax; m_run <= m_ctrl[0];
                m_f <= cap(m_per, m_d0, m_d1, m_sp, m_ctrl);
            end else begin
                m_t <= m_t + 32'd1;
            end
        end

    always @(negedge clock) begin
        checks++;
        if (sensor_signal_o !== exp_out) begin
            errors++;
            $display("FAIL model_cmp at %0t: got %b expected %b", $time, sensor_signal_o, exp_out);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        @(posedge clock);
        #1 bus.write = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a; bus.read = 1'b1;
        #1 chk(nm, bus.readdata, exp);
        bus.read = 1'b0;
    endtask

    // pos counts negedges since the enabling write; output at pos n shows frame offset n-2
    task automatic goto(input int n);
        while (pos < n) begin
            @(negedge clock);
            pos++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nz;
        bus.write = 1'b0; bus.read = 1'b0; bus.address = 3'd0; bus.writedata = 32'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        rd("rst_ctrl", 3'd0, 32'd0);
        rd("rst_period", 3'd1, 32'd200);
        rd("rst_delay0", 3'd2, 32'd100000);
        rd("rst_spacing", 3'd4, 32'd1000);
        rd("rst_status", 3'd5, 32'd0);
        rd("rst_filler6", 3'd6, 32'hDEAD_BEEF);
        wr(3'd5, 32'h1234_5678);
        wr(3'd7, 32'h0);
        rd("ro_status", 3'd5, 32'd0);
        rd("ro_filler7", 3'd7, 32'hDEAD_BEEF);
        nz = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if (sensor_signal_o != 4'd0) nz++;
        end
        chk("idle_quiet", 32'(nz), 32'd0);

        // basic frames, shadowing of DELAY0, stop at frame end
        wr(3'd2, 32'd60); wr(3'd3, 32'd80); wr(3'd4, 32'd10); wr(3'd0, 32'd1);
        pos = 0;
        goto(1);    chk("f0_lat", 32'(sensor_signal_o), 32'h0);
        goto(2);    chk("f0_sync_on", 32'(sensor_signal_o), 32'hF);
        goto(21);   chk("f0_sync_last", 32'(sensor_signal_o), 32'hF);
        goto(22);   chk("f0_sync_off", 32'(sensor_signal_o), 32'h0);
        goto(62);   chk("f0_s0_60", 32'(sensor_signal_o), 32'h1);
        goto(82);   chk("f0_s2_80", 32'(sensor_signal_o), 32'h4);
        goto(84);   chk("f0_s2_82", 32'(sensor_signal_o), 32'h4);
        goto(85);   chk("f0_s2_end", 32'(sensor_signal_o), 32'h0);
        goto(202);  chk("f1_sync_on", 32'(sensor_signal_o), 32'hF);
        goto(225);  chk("f1_sync_last", 32'(sensor_signal_o), 32'hF);
        goto(226);  chk("f1_sync_off", 32'(sensor_signal_o), 32'h0);
        goto(230);  rd("f1_status", 3'd5, 32'hC000_0001);
        goto(262);  chk("f1_no_d0", 32'(sensor_signal_o), 32'h0);
        goto(282);  chk("f1_s0_80", 32'(sensor_signal_o), 32'h1);
        goto(432);  wr(3'd2, 32'd120);
        goto(462);  chk("f2_old_d0", 32'(sensor_signal_o), 32'h1);
        goto(522);  chk("f2_not_new", 32'(sensor_signal_o), 32'h0);
        goto(862);  chk("f4_not_old", 32'(sensor_signal_o), 32'h0);
        goto(922);  chk("f4_new_d0", 32'(sensor_signal_o), 32'h1);
        goto(930);  wr(3'd0, 32'd0);
        goto(952);  chk("f4_s3_150", 32'(sensor_signal_o), 32'h8);
        goto(1002); chk("stop_quiet", 32'(sensor_signal_o), 32'h0);
        goto(1010); rd("stop_status", 3'd5, 32'h4000_0005);

        // sync code widths with data and skip set
        do_reset();
        wr(3'd0, 32'd7);
        pos = 0;
        goto(45);   chk("c6_last", 32'(sensor_signal_o), 32'hF);
        goto(46);   chk("c6_off", 32'(sensor_signal_o), 32'h0);
        goto(249);  chk("c7_last", 32'(sensor_signal_o), 32'hF);
        goto(250);  chk("c7_off", 32'(sensor_signal_o), 32'h0);
        goto(260);  wr(3'd0, 32'd0);
        goto(402);  rd("c_status", 3'd5, 32'h0000_0002);

        // minimum period, late windows, async reset during a pulse
        do_reset();
        wr(3'd1, 32'd30); wr(3'd2, 32'd10); wr(3'd4, 32'd10); wr(3'd0, 32'd1);
        pos = 0;
        goto(22);   chk("mp_s1_20", 32'(sensor_signal_o), 32'h2);
        goto(42);   chk("mp_s3_40", 32'(sensor_signal_o), 32'h8);
        goto(44);   chk("mp_s3_42", 32'(sensor_signal_o), 32'h8);
        goto(45);   chk("mp_s3_end", 32'(sensor_signal_o), 32'h0);
        goto(51);   chk("mp_f1_start", 32'(sensor_signal_o), 32'hF);
        goto(60);   wr(3'd2, 32'd47);
        goto(146);  chk("tr_46", 32'(sensor_signal_o), 32'h0);
        goto(147);  chk("tr_47", 32'(sensor_signal_o), 32'h1);
        goto(148);  chk("tr_48", 32'(sensor_signal_o), 32'h1);
        goto(149);  chk("tr_wrap", 32'(sensor_signal_o), 32'hF);
        goto(173);  chk("tr_f3_off", 32'(sensor_signal_o), 32'h0);
        goto(245);  chk("ar_pulse", 32'(sensor_signal_o), 32'h1);
        #2 reset = 1'b1;
        #1 chk("ar_drop", 32'(sensor_signal_o), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        rd("ar_status", 3'd5, 32'd0);
        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
